// File: rtl/cpu_player.sv
// -----------------------------------------------------------------------------
// cpu_player
//   Autonomous opponent that drives the right-hand push-button line in place of
//   a human player. It watches the round cues and emits press pulses on pb_cpu,
//   which is muxed onto pbr ahead of the button receive chain. Reaction time,
//   false-start rate and speed-round tap rate scale with the difficulty input.
//   Runs in the 500 Hz clk domain.
//
// Ports
//   clk          : system clock (500 Hz tick domain)
//   rst          : asynchronous active-low reset
//   enable       : 1 = CPU plays, 0 = forced to IDLE
//   difficulty   : 0 easiest .. 3 hardest
//   leds_on      : round cue lit (level)
//   fake         : current cue is a fake round
//   speed_round  : speed round active (level)
//   clear        : round over / re-arm request from the master controller
//   pb_cpu       : emulated button level (registered)
//   false_start  : one-cycle pulse when the CPU presses on a fake cue
//   presses      : saturating count of pb_cpu rising edges
//   state_o      : current FSM state encoding
//
// Handshake: there is no valid/ready pairing here. All inputs are level
//   signals sampled on every rising clk edge; leds_on is edge-detected
//   internally, and every output is a register updated on the same edge.
// -----------------------------------------------------------------------------
module cpu_player #(
   parameter int unsigned BASE_DELAY   = 90,
   parameter int unsigned DELAY_STEP   = 20,
   parameter logic [7:0]  JITTER_MASK  = 8'h1F,
   parameter int unsigned HOLD         = 4,
   parameter int unsigned SPEED_PERIOD = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] difficulty,
   input  logic       leds_on,
   input  logic       fake,
   input  logic       speed_round,
   input  logic       clear,
   output logic       pb_cpu,
   output logic       false_start,
   output logic [7:0] presses,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_WAIT  = 3'd2,
      ST_PRESS = 3'd3,
      ST_DONE  = 3'd4,
      ST_SPEED = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [8:0] cnt_q, cnt_d;          // shared: reaction delay, hold, tap phase
   logic [7:0] lfsr_q, lfsr_d;
   logic       leds_on_q;             // registered copy of leds_on
   logic       fake_l_q, fake_l_d;
   logic       go_l_q, go_l_d;
   logic       pb_q, pb_d;
   logic       fs_q, fs_d;
   logic [7:0] presses_q, presses_d;

   logic       cue_w;
   logic       go_w;
   logic [8:0] delay_w;
   logic [8:0] period_w;
   logic [8:0] tap_next_w;

   assign cue_w = leds_on & ~leds_on_q;

   // Galois form of x^8+x^6+x^5+x^4+1; maximal length, so 0 is never reached
   // from a non-zero seed.
   assign lfsr_d = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h71 : 8'h00);

   // Harder levels need three zero bits instead of two, so they fall for
   // fake cues half as often.
   assign go_w = difficulty[1] ? (lfsr_q[7:5] == 3'b000) : (lfsr_q[7:6] == 2'b00);

   assign delay_w = 9'(BASE_DELAY) - (9'(difficulty) * 9'(DELAY_STEP))
                  + {1'b0, lfsr_q & JITTER_MASK};

   assign period_w   = 9'(SPEED_PERIOD) >> difficulty;
   assign tap_next_w = (cnt_q >= period_w - 9'd1) ? 9'd0 : cnt_q + 9'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fake_l_d = fake_l_q;
      go_l_d   = go_l_q;
      pb_d     = 1'b0;
      fs_d     = 1'b0;

      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = 9'd0;
      end else if (clear) begin
         // Also aborts a press in progress, truncating the hold.
         state_d = ST_ARMED;
         cnt_d   = 9'd0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
               if (speed_round) begin
                  state_d = ST_SPEED;
                  cnt_d   = 9'd0;
                  pb_d    = 1'b1;       // tap phase 0 is always inside the hold
               end else if (cue_w) begin
                  state_d  = ST_WAIT;
                  cnt_d    = delay_w;
                  fake_l_d = fake;
                  go_l_d   = go_w;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 9'd0) begin
                  if (fake_l_q && !go_l_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_PRESS;
                     cnt_d   = 9'(HOLD - 1);
                     pb_d    = 1'b1;
                     fs_d    = fake_l_q;
                  end
               end else begin
                  cnt_d = cnt_q - 9'd1;
               end
            end
            ST_PRESS: begin
               if (cnt_q == 9'd0) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - 9'd1;
                  pb_d  = 1'b1;
               end
            end
            ST_DONE: state_d = ST_DONE;   // one press per round; wait for clear
            ST_SPEED: begin
               if (!speed_round) begin
                  state_d = ST_DONE;
                  cnt_d   = 9'd0;
               end else begin
                  cnt_d = tap_next_w;
                  pb_d  = (tap_next_w < 9'(HOLD));
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 9'd0;
            end
         endcase
      end
   end

   // Count on the next-state rising edge so presses moves with pb_cpu.
   assign presses_d = (pb_d && !pb_q && (presses_q != 8'hFF)) ? presses_q + 8'd1
                                                              : presses_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 9'd0;
         lfsr_q    <= 8'hA5;
         leds_on_q <= 1'b0;
         fake_l_q  <= 1'b0;
         go_l_q    <= 1'b0;
         pb_q      <= 1'b0;
         fs_q      <= 1'b0;
         presses_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         leds_on_q <= leds_on;
         fake_l_q  <= fake_l_d;
         go_l_q    <= go_l_d;
         pb_q      <= pb_d;
         fs_q      <= fs_d;
         presses_q <= presses_d;
      end
   end

   assign pb_cpu      = pb_q;
   assign false_start = fs_q;
   assign presses     = presses_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_cpu_player.sv
// -----------------------------------------------------------------------------
// tb_cpu_player
//   Directed bench for cpu_player built with JITTER_MASK = 0 so reaction delays
//   are exact: D = 90 - 20*difficulty. A reference copy of the LFSR (seed A5,
//   x^8+x^6+x^5+x^4+1) selects the cycle on which a fake cue is presented.
// -----------------------------------------------------------------------------
module tb_cpu_player;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] difficulty;
   logic       leds_on;
   logic       fake;
   logic       speed_round;
   logic       clear;
   logic       pb_cpu;
   logic       false_start;
   logic [7:0] presses;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_WAIT = 3'd2,
                          S_PRESS = 3'd3, S_DONE = 3'd4, S_SPEED = 3'd5;

   cpu_player #(
      .BASE_DELAY(90), .DELAY_STEP(20), .JITTER_MASK(8'h00),
      .HOLD(4), .SPEED_PERIOD(64)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .difficulty(difficulty),
      .leds_on(leds_on), .fake(fake), .speed_round(speed_round), .clear(clear),
      .pb_cpu(pb_cpu), .false_start(false_start), .presses(presses),
      .state_o(state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Reference LFSR, tracks the value the DUT holds between edges.
   logic [7:0] m_lfsr;
   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= 8'hA5;
      else      m_lfsr <= {m_lfsr[6:0], 1'b0} ^ (m_lfsr[7] ? 8'h71 : 8'h00);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clear cycle with leds_on low; returns at a negedge with the DUT ARMED.
   task automatic drive_clear();
      @(negedge clk);
      clear   = 1'b1;
      leds_on = 1'b0;
      tick();
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Edges after the cue edge until pb_cpu is seen high (bounded).
   task automatic wait_rise(output int n);
      n = 0;
      while (pb_cpu !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #12;
      checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, S_IDLE); end
      checks++; if (pb_cpu !== 1'b0) begin errors++; $display("FAIL reset_pb: got %b expected 0", pb_cpu); end
      checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", false_start); end
      checks++; if (presses !== 8'd0) begin errors++; $display("FAIL reset_presses: got %0d expected 0", presses); end
   endtask

   task automatic test_react_d0();
      int n, h;
      @(negedge clk);
      rst = 1'b1;
      tick();
      checks++; if (state_o !== S_ARMED) begin errors++; $display("FAIL idle_to_armed: got %0d expected %0d", state_o, S_ARMED); end
      @(negedge clk);
      leds_on = 1'b1;
      tick();
      checks++; if (state_o !== S_WAIT) begin errors++; $display("FAIL d0_wait: got %0d expected %0d", state_o, S_WAIT); end
      wait_rise(n);
      checks++; if (n != 91) begin errors++; $display("FAIL d0_latency: got %0d expected 91", n); end
      h = 0;
      while (pb_cpu === 1'b1 && h < 20) begin
         h++;
         tick();
      end
      checks++; if (h != 4) begin errors++; $display("FAIL d0_hold: got %0d expected 4", h); end
      checks++; if (presses !== 8'd1) begin errors++; $display("FAIL d0_presses: got %0d expected 1", presses); end
      checks++; if (state_o !== S_DONE) begin errors++; $display("FAIL d0_done: got %0d expected %0d", state_o, S_DONE); end
   endtask

   task automatic test_react_d3();
      int n;
      difficulty = 2'd3;
      drive_clear();
      leds_on = 1'b1;
      tick();
      wait_rise(n);
      checks++; if (n != 31) begin errors++; $display("FAIL d3_latency: got %0d expected 31", n); end
      repeat (6) tick();
      checks++; if (presses !== 8'd2) begin errors++; $display("FAIL d3_presses: got %0d expected 2", presses); end
      // second cue without clear must be ignored
      @(negedge clk); leds_on = 1'b0;
      tick();
      @(negedge clk); leds_on = 1'b1;
      repeat (60) tick();
      checks++; if (presses !== 8'd2) begin errors++; $display("FAIL d3_no_second: got %0d expected 2", presses); end
      checks++; if (state_o !== S_DONE) begin errors++; $display("FAIL d3_stay_done: got %0d expected %0d", state_o, S_DONE); end
      // clear while leds_on is still high: no edge once ARMED, so no press
      @(negedge clk); clear = 1'b1;
      tick();
      @(negedge clk); clear = 1'b0;
      repeat (60) tick();
      checks++; if (state_o !== S_ARMED) begin errors++; $display("FAIL level_no_cue_state: got %0d expected %0d", state_o, S_ARMED); end
      checks++; if (presses !== 8'd2) begin errors++; $display("FAIL level_no_cue: got %0d expected 2", presses); end
      // proper clear then cue
      drive_clear();
      leds_on = 1'b1;
      tick();
      wait_rise(n);
      checks++; if (n != 31) begin errors++; $display("FAIL d3_latency2: got %0d expected 31", n); end
      repeat (6) tick();
      checks++; if (presses !== 8'd3) begin errors++; $display("FAIL d3_presses2: got %0d expected 3", presses); end
   endtask

   task automatic test_speed();
      int rises, high, bad, last;
      logic prev;
      difficulty = 2'd1;
      drive_clear();
      speed_round = 1'b1;
      rises = 0; high = 0; bad = 0; last = 0; prev = 1'b0;
      for (int i = 0; i < 256; i++) begin
         tick();
         if (pb_cpu === 1'b1) high++;
         if (pb_cpu === 1'b1 && !prev) begin
            if (rises > 0 && (i - last) != 32) bad++;
            rises++;
            last = i;
         end
         prev = pb_cpu;
      end
      checks++; if (rises != 8) begin errors++; $display("FAIL speed_rises: got %0d expected 8", rises); end
      checks++; if (bad != 0) begin errors++; $display("FAIL speed_period: got %0d bad gaps expected 0", bad); end
      checks++; if (high != 32) begin errors++; $display("FAIL speed_duty: got %0d high cycles expected 32", high); end
      checks++; if (presses !== 8'd11) begin errors++; $display("FAIL speed_presses: got %0d expected 11", presses); end
      @(negedge clk); speed_round = 1'b0;
      tick();
      checks++; if (state_o !== S_DONE) begin errors++; $display("FAIL speed_end_state: got %0d expected %0d", state_o, S_DONE); end
      checks++; if (pb_cpu !== 1'b0) begin errors++; $display("FAIL speed_end_pb: got %b expected 0", pb_cpu); end
   endtask

   task automatic test_clear_speed();
      @(negedge clk);
      clear = 1'b1;
      speed_round = 1'b1;
      tick();
      checks++; if (state_o !== S_ARMED) begin errors++; $display("FAIL clr_spd_armed: got %0d expected %0d", state_o, S_ARMED); end
      @(negedge clk); clear = 1'b0;
      tick();
      checks++; if (state_o !== S_SPEED) begin errors++; $display("FAIL clr_spd_speed: got %0d expected %0d", state_o, S_SPEED); end
      checks++; if (pb_cpu !== 1'b1) begin errors++; $display("FAIL clr_spd_tap0: got %b expected 1", pb_cpu); end
      @(negedge clk); speed_round = 1'b0;
      tick();
      checks++; if (pb_cpu !== 1'b0) begin errors++; $display("FAIL clr_spd_drop_pb: got %b expected 0", pb_cpu); end
      checks++; if (state_o !== S_DONE) begin errors++; $display("FAIL clr_spd_done: got %0d expected %0d", state_o, S_DONE); end
      checks++; if (presses !== 8'd12) begin errors++; $display("FAIL clr_spd_presses: got %0d expected 12", presses); end
   endtask

   task automatic test_fake();
      int n, seen;
      bit found;
      difficulty = 2'd0;
      fake = 1'b1;
      // go case: lfsr[7:6] == 00
      drive_clear();
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         if (m_lfsr[7:6] == 2'b00) found = 1'b1;
         else @(negedge clk);
      end
      checks++; if (!found) begin errors++; $display("FAIL fake_go_seek: got 0 expected 1"); end
      leds_on = 1'b1;
      tick();
      wait_rise(n);
      checks++; if (n != 91) begin errors++; $display("FAIL fake_go_latency: got %0d expected 91", n); end
      checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fake_go_fs: got %b expected 1", false_start); end
      tick();
      checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL fake_go_fs_pulse: got %b expected 0", false_start); end
      repeat (6) tick();
      checks++; if (presses !== 8'd13) begin errors++; $display("FAIL fake_go_presses: got %0d expected 13", presses); end
      // no-go case: lfsr[7:6] == 01
      drive_clear();
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         if (m_lfsr[7:6] == 2'b01) found = 1'b1;
         else @(negedge clk);
      end
      checks++; if (!found) begin errors++; $display("FAIL fake_nogo_seek: got 0 expected 1"); end
      leds_on = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (pb_cpu !== 1'b0 || false_start !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL fake_nogo_press: got %0d active cycles expected 0", seen); end
      checks++; if (state_o !== S_DONE) begin errors++; $display("FAIL fake_nogo_done: got %0d expected %0d", state_o, S_DONE); end
      checks++; if (presses !== 8'd13) begin errors++; $display("FAIL fake_nogo_presses: got %0d expected 13", presses); end
      fake = 1'b0;
   endtask

   task automatic test_clear_mid_press();
      int n;
      difficulty = 2'd3;
      drive_clear();
      leds_on = 1'b1;
      tick();
      wait_rise(n);
      tick();
      checks++; if (pb_cpu !== 1'b1) begin errors++; $display("FAIL midpress_hold2: got %b expected 1", pb_cpu); end
      @(negedge clk); clear = 1'b1;
      tick();
      checks++; if (pb_cpu !== 1'b0) begin errors++; $display("FAIL midpress_pb: got %b expected 0", pb_cpu); end
      checks++; if (state_o !== S_ARMED) begin errors++; $display("FAIL midpress_state: got %0d expected %0d", state_o, S_ARMED); end
      checks++; if (presses !== 8'd14) begin errors++; $display("FAIL midpress_presses: got %0d expected 14", presses); end
      @(negedge clk); clear = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk); leds_on = 1'b0;
      tick();
      @(negedge clk); leds_on = 1'b1;
      repeat (11) tick();
      checks++; if (state_o !== S_WAIT) begin errors++; $display("FAIL midwait_state: got %0d expected %0d", state_o, S_WAIT); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL async_rst_state: got %0d expected %0d", state_o, S_IDLE); end
      checks++; if (pb_cpu !== 1'b0) begin errors++; $display("FAIL async_rst_pb: got %b expected 0", pb_cpu); end
      checks++; if (presses !== 8'd0) begin errors++; $display("FAIL async_rst_presses: got %0d expected 0", presses); end
      leds_on = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_saturate();
      int n;
      difficulty = 2'd3;
      @(negedge clk); rst = 1'b1;
      tick();
      @(negedge clk); speed_round = 1'b1;
      repeat (2400) tick();
      checks++; if (presses !== 8'd255) begin errors++; $display("FAIL sat_presses: got %0d expected 255", presses); end
      n = 0;
      while (pb_cpu !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      @(negedge clk); enable = 1'b0;
      tick();
      checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL disable_state: got %0d expected %0d", state_o, S_IDLE); end
      checks++; if (pb_cpu !== 1'b0) begin errors++; $display("FAIL disable_pb: got %b expected 0", pb_cpu); end
      checks++; if (presses !== 8'd255) begin errors++; $display("FAIL disable_presses: got %0d expected 255", presses); end
      speed_round = 1'b0;
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      rst         = 1'b0;
      enable      = 1'b1;
      difficulty  = 2'd0;
      leds_on     = 1'b0;
      fake        = 1'b0;
      speed_round = 1'b0;
      clear       = 1'b0;
      test_reset();
      test_react_d0();
      test_react_d3();
      test_speed();
      test_clear_speed();
      test_fake();
      test_clear_mid_press();
      test_reset_mid_wait();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_player.md
Name: cpu_player

Overview:
- Autonomous opponent that drives the right-hand push-button line in place of a human player.
- It is the transmitter end of the button interface:
  - watches the round cues (leds_on, fake, speed_round, clear);
  - emits press pulses on pb_cpu, which is muxed onto pbr ahead of the PBL/SYNC/OPP receive chain.
- Reaction time, false-start rate and speed-round tap rate scale with a 2-bit difficulty input.
- Runs in the 500 Hz clk domain.

Parameters:
- BASE_DELAY, 90, reaction delay in clk cycles at difficulty 0 (must be ≥ 3*DELAY_STEP).
- DELAY_STEP, 20, cycles removed from the delay per difficulty level.
- JITTER_MASK, 8'h1F, mask applied to the LFSR value added to the delay (0 gives deterministic timing).
- HOLD, 4, cycles pb_cpu stays high per press (≥ 1).
- SPEED_PERIOD, 64, cycles between taps in a speed round at difficulty 0 (must satisfy SPEED_PERIOD>>3 ≥ 2*HOLD).

Ports:
- clk, input, 1: system clock, 500 Hz tick domain.
- rst, input, 1: asynchronous active-low reset.
- enable, input, 1: 1 means the CPU plays; 0 forces IDLE.
- difficulty, input, 2: 0 is easiest, 3 is hardest.
- leds_on, input, 1: round cue lit (level).
- fake, input, 1: current cue is a fake round; pressing it is a false start.
- speed_round, input, 1: speed round active (level).
- clear, input, 1: round over / reset request from the master controller.
- pb_cpu, output, 1: emulated button level.
- false_start, output, 1: one-cycle pulse when the CPU presses on a fake cue.
- presses, output, 8: count of pb_cpu rising edges, saturating.
- state_o, output, 3: current FSM state encoding.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pb_cpu=0, false_start=0, presses=0;
  - lfsr=8'hA5, counters=0, leds_on_d=0.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every clk cycle regardless of state; never reaches 0.
- Delay computation: D = BASE_DELAY - difficulty*DELAY_STEP + (lfsr & JITTER_MASK), computed in 9 bits.
- Cue edge: cue = leds_on & ~leds_on_d, where leds_on_d is a registered copy of leds_on.
- State encodings: IDLE=0, ARMED=1, WAIT=2, PRESS=3, DONE=4, SPEED=5.
- Priority each cycle: enable=0 > clear > speed_round > cue > counter events.
- enable=0:
  - next state IDLE, pb_cpu=0 next cycle;
  - presses holds its value.
- clear=1 (enable=1): next state ARMED, pb_cpu=0, pending delay discarded. This also applies mid-PRESS, which truncates the hold.
- IDLE: enable=1 → ARMED.
- ARMED:
  - speed_round=1 → SPEED with tap counter=0.
  - Else cue=1 → WAIT with counter=D.
  - If fake=1 at the cue cycle, latch fake_l=1 and latch go_l = (lfsr[7:6]==0) >> difficulty? No: go_l = (lfsr[7:6]==2'b00) for difficulty<2, and go_l = (lfsr[7:5]==3'b000) for difficulty≥2.
- WAIT:
  - Counter decrements each cycle.
  - At counter==0:
    - if fake_l=1 and go_l=0 → DONE, no press;
    - otherwise → PRESS with hold counter=HOLD-1, pb_cpu=1.
  - If fake_l=1 on entry to PRESS, false_start=1 for exactly that cycle.
  - Net latency: pb_cpu rises D+1 cycles after the cycle in which cue=1.
- PRESS:
  - pb_cpu=1 for exactly HOLD cycles.
  - On expiry → DONE, pb_cpu=0.
- DONE:
  - Waits for clear; pb_cpu=0.
  - A new leds_on edge without clear is ignored (one press per round).
- SPEED:
  - Tap period P = SPEED_PERIOD >> difficulty.
  - pb_cpu=1 for tap counter values 0..HOLD-1, else 0; counter wraps at P-1 → 0.
  - speed_round falling → DONE, pb_cpu=0 next cycle.
- presses: increments on every 0→1 transition of pb_cpu; holds at 255 (no wrap).
- Simultaneous clear and speed_round rising: clear wins (ARMED), SPEED entered the following cycle.
- leds_on already high when reaching ARMED: no cue (edge-only), so no press.
- Reset asserted mid-operation: all outputs go to reset values immediately, independent of clk.

Test Plan:
- Reset → IDLE; release with enable=1, JITTER_MASK=0, difficulty=0; raise leds_on → pb_cpu rises exactly 91 cycles after the cue cycle, high 4 cycles, presses=1, state DONE.
- difficulty=3, same setup → pb_cpu rises 31 cycles after the cue. A second leds_on pulse without clear → no press. clear then cue → presses=2.
- speed_round=1 at difficulty 1 for 256 cycles → pb_cpu period 32, duty 4/32, presses=8. Drop speed_round → DONE, pb_cpu=0 next cycle.
- Fake cue, lfsr forced so lfsr[7:6]=00, difficulty 0 → press after D+1 cycles with false_start pulsed one cycle. With lfsr[7:6]=01 → DONE with no press.
- Mid-PRESS (2nd hold cycle) assert clear → pb_cpu=0 next cycle, state ARMED. Mid-WAIT drop rst → pb_cpu=0 and presses=0 asynchronously.
- 300 speed taps at difficulty 3 (P=8) → presses saturates at 255. enable=0 → IDLE, pb_cpu=0, presses stays 255.
